// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_WORD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/uart_word_packer.sv
// Assembles little-endian bytes into 32-bit words; strobes word_vld for one cycle
// after the last byte of each word. clear restarts assembly from byte 0.
module uart_word_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_vld,
  output logic [31:0] word_data
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] cnt_p0;
  logic [31:0]      shift_p0;
  logic             vld_p1;

  assign word_last = byte_vld && (cnt_p0 == CNT_W'(WORD_BYTES - 1));

  // p0: shift register and byte counter; p1: completed-word strobe
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_p0   <= '0;
      shift_p0 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= word_last;
      if (byte_vld) begin
        shift_p0 <= {byte_data, shift_p0[31:8]};
        cnt_p0   <= cnt_p0 + 1'b1;
      end
    end
  end

  assign word_vld  = vld_p1;
  assign word_data = shift_p0;

endmodule

// File: rtl/uart_program_loader.sv
// Parses a LEN-prefixed little-endian word stream from the UART into instruction memory.
// Define UART_LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_data_valid,
  input  logic [7:0]            io_data_packet,
  output logic                  io_mem_we,
  output logic [ADDR_WIDTH-1:0] io_mem_addr,
  output logic [31:0]           io_mem_wdata,
  output logic                  io_load_active,
  output logic                  io_load_done,
  output logic                  io_load_error
);

  localparam logic [31:0] CAPACITY = 32'((1 << ADDR_WIDTH) - START_ADDR);
`ifdef UART_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL_ST = ST_CHECK;
`else
  localparam loader_state_t TAIL_ST = ST_DONE;
`endif

  loader_state_t         state_q, state_d;
  logic [7:0]            len_lo_q;
  logic [LEN_WIDTH-1:0]  len_q, word_cnt_q, len_in;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  frame_start, byte_in_word, word_last, pack_clear;
  logic                  done_q, error_q, active_q;

  assign len_in       = {io_data_packet, len_lo_q};
  assign byte_in_word = io_data_valid && (state_q == ST_WORD);
  assign pack_clear   = !reset_n || frame_start;

  uart_word_packer u_packer (
    .clk       (clk),
    .clear     (pack_clear),
    .byte_vld  (byte_in_word),
    .byte_data (io_data_packet),
    .word_last (word_last),
    .word_vld  (io_mem_we),
    .word_data (io_mem_wdata)
  );

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       sum_ok;

  assign sum_ok = (8'(sum_q + io_data_packet) == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (frame_start) begin
      sum_q <= io_data_packet;
    end else if (io_data_valid && (state_q == ST_LEN_HI || state_q == ST_WORD)) begin
      sum_q <= sum_q + io_data_packet;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      // DONE/ERROR last one cycle; a byte arriving then opens the next frame
      ST_IDLE, ST_DONE, ST_ERROR: begin
        state_d = ST_IDLE;
        if (io_data_valid) begin
          state_d     = ST_LEN_HI;
          frame_start = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (io_data_valid) begin
          if (32'(len_in) > CAPACITY)  state_d = ST_ERROR;
          else if (len_in == '0)       state_d = TAIL_ST;
          else                         state_d = ST_WORD;
        end
      end
      ST_WORD: begin
        if (word_last && ((word_cnt_q + LEN_WIDTH'(1)) == len_q)) state_d = TAIL_ST;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (io_data_valid) state_d = sum_ok ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= ADDR_WIDTH'(START_ADDR);
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == ST_DONE);
      error_q  <= (state_q == ST_ERROR);
      // stays high through the status pulse cycle
      active_q <= (state_d != ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
      if (frame_start) begin
        len_lo_q   <= io_data_packet;
        word_cnt_q <= '0;
        addr_q     <= ADDR_WIDTH'(START_ADDR);
      end else begin
        if (state_q == ST_LEN_HI && io_data_valid) len_q <= len_in;
        if (word_last) word_cnt_q <= word_cnt_q + LEN_WIDTH'(1);
        if (io_mem_we) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign io_mem_addr    = addr_q;
  assign io_load_active = active_q;
  assign io_load_done   = done_q;
  assign io_load_error  = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized bench for uart_program_loader against a frame-level expectation model.
module tb_uart_program_loader;

  localparam int AW  = 4;
  localparam int SA  = 3;
  localparam int CAP = (1 << AW) - SA;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          io_data_valid = 1'b0;
  logic [7:0]    io_data_packet = 8'h00;
  logic          io_mem_we;
  logic [AW-1:0] io_mem_addr;
  logic [31:0]   io_mem_wdata;
  logic          io_load_active, io_load_done, io_load_error;

  uart_program_loader #(.ADDR_WIDTH(AW), .START_ADDR(SA)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io_data_valid  (io_data_valid),
    .io_data_packet (io_data_packet),
    .io_mem_we      (io_mem_we),
    .io_mem_addr    (io_mem_addr),
    .io_mem_wdata   (io_mem_wdata),
    .io_load_active (io_load_active),
    .io_load_done   (io_load_done),
    .io_load_error  (io_load_error)
  );

  always #5 clk = ~clk;

  // cyc == E during the interval that follows active edge E
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // expectations keyed by the edge that opens the interval being observed
  bit          exp_we[int];
  logic [31:0] exp_data[int];
  int          exp_addr[int];
  bit          exp_act[int];
  bit          exp_done[int];
  bit          exp_err[int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("mem_we", 32'(io_mem_we), 32'(exp_we.exists(cyc)));
      if (exp_we.exists(cyc)) begin
        check_val("mem_addr", 32'(io_mem_addr), 32'(exp_addr[cyc]));
        check_val("mem_wdata", io_mem_wdata, exp_data[cyc]);
      end
      check_val("load_active", 32'(io_load_active), 32'(exp_act.exists(cyc)));
      check_val("load_done", 32'(io_load_done), 32'(exp_done.exists(cyc)));
      check_val("load_error", 32'(io_load_error), 32'(exp_err.exists(cyc)));
    end
  end

  function automatic logic [7:0] csum(input bq_t b);
    logic [7:0] acc;
    acc = 8'h00;
    foreach (b[i]) acc = acc + b[i];
    return 8'(8'h00 - acc);
  endfunction

  // Drives one frame's bytes and records what the loader must do for them.
  task automatic drive_frame(input bq_t b, input bit complete, input int gapmax, input bit hold);
    int len, e, w, gap;
    bit bad;
    logic [7:0] total;
    len = int'({b[1], b[0]});
    bad = (len > CAP);
    e = 0;
    for (int i = 0; i < b.size(); i++) begin
      gap = (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
      repeat (gap) begin
        @(negedge clk);
        io_data_valid  = 1'b0;
        io_data_packet = 8'($urandom);
        if (i > 0) exp_act[cyc + 1] = 1'b1;
      end
      @(negedge clk);
      io_data_valid  = 1'b1;
      io_data_packet = b[i];
      e = cyc + 1;
      exp_act[e] = 1'b1;
      w = (i - 5) / 4;
      if (!bad && i >= 5 && ((i - 2) % 4) == 3 && w < len) begin
        exp_we[e]   = 1'b1;
        exp_addr[e] = SA + w;
        exp_data[e] = {b[i], b[i-1], b[i-2], b[i-3]};
      end
    end
    if (complete) begin
      exp_act[e + 1] = 1'b1;
      total = 8'h00;
      foreach (b[i]) total = total + b[i];
      if (bad || (CSUM && total != 8'h00)) exp_err[e + 1] = 1'b1;
      else                                 exp_done[e + 1] = 1'b1;
    end
    if (!hold) begin
      @(negedge clk);
      io_data_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      io_data_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    io_data_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    check_val("rst_mem_we", 32'(io_mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(io_mem_addr), 32'(SA));
    check_val("rst_mem_wdata", io_mem_wdata, 32'd0);
    check_val("rst_active", 32'(io_load_active), 32'd0);
    check_val("rst_done", 32'(io_load_done), 32'd0);
    check_val("rst_error", 32'(io_load_error), 32'd0);
  endtask

  function automatic bq_t rand_frame();
    bq_t b;
    int len, r;
    logic [31:0] w;
    logic [7:0] c;
    r = int'($urandom_range(0, 9));
    if (r == 0)      len = 0;
    else if (r == 1) len = CAP + 1 + int'($urandom_range(0, 3));
    else if (r == 2) len = int'($urandom_range(CAP + 1, 65535));
    else             len = int'($urandom_range(1, CAP));
    b.push_back(8'(len));
    b.push_back(8'(len >> 8));
    if (len <= CAP) begin
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        for (int k = 0; k < 4; k++) b.push_back(8'(w >> (8 * k)));
      end
      if (CSUM) begin
        c = csum(b);
        if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
        b.push_back(c);
      end
    end
    return b;
  endfunction

  initial begin
    bq_t f;
    do_reset(3);
    mon_en = 1'b1;

    f = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    if (CSUM) f.push_back(8'hEB);
    drive_frame(f, 1'b1, 0, 1'b0);
    idle(4);

    f = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
    if (CSUM) f.push_back(csum(f));
    drive_frame(f, 1'b1, 0, 1'b0);
    idle(4);

    f = '{8'h00, 8'h00};
    if (CSUM) f.push_back(8'h00);
    drive_frame(f, 1'b1, 0, 1'b0);
    idle(4);

    // oversize LEN, then a frame starting in the error cycle
    f = '{8'h11, 8'h00};
    drive_frame(f, 1'b1, 0, 1'b1);
    f = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    if (CSUM) f.push_back(csum(f));
    drive_frame(f, 1'b1, 0, 1'b0);
    idle(3);

    f = '{8'(CAP + 1), 8'h00};
    drive_frame(f, 1'b1, 0, 1'b0);
    idle(3);

    // exactly fills memory up to the top address
    f = '{8'(CAP), 8'h00};
    for (int i = 0; i < CAP * 4; i++) f.push_back(8'($urandom));
    if (CSUM) f.push_back(csum(f));
    drive_frame(f, 1'b1, 1, 1'b0);
    idle(3);

    if (CSUM) begin
      f = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
      drive_frame(f, 1'b1, 0, 1'b0);
      idle(3);
    end

    f = '{8'h01, 8'h00, 8'h78, 8'h56};
    drive_frame(f, 1'b0, 0, 1'b1);
    do_reset(2);
    f = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    if (CSUM) f.push_back(8'hEB);
    drive_frame(f, 1'b1, 0, 1'b0);
    idle(3);

    repeat (30) begin
      f = rand_frame();
      drive_frame(f, 1'b1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
